uop_queue: RTL and testbench
============================

# uop_queue

Multi-lane micro-op queue between the x86 decoder and the backend issue stage. The decoder writes up to ENQ_W `DecoderTypes::micro_op_t` entries per cycle in program order. The backend reads up to DEQ_W oldest entries per cycle, also in program order. The block generalises the single micro-op hand-off to a parametrised-depth circular buffer with multi-lane enqueue and dequeue, a flush input and sticky protocol-error reporting.

## Interface
- DEPTH, 16, number of entries; power of two, at least 4, at least ENQ_W and at least DEQ_W
- ENQ_W, 2, enqueue lanes per cycle (1..4)
- DEQ_W, 2, dequeue lanes per cycle (1..4)
- UOP_W, $bits(DecoderTypes::micro_op_t), entry width in bits
- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (pipeline redirect)
- enq_valid  in  ENQ_W  per-lane write request; must be contiguous from lane 0
- enq_data  in  ENQ_W*UOP_W  lane i occupies bits [i*UOP_W +: UOP_W]
- enq_ready  out  1  queue can accept a full ENQ_W-lane write this cycle
- deq_valid  out  DEQ_W  lane i holds the (i+1)-th oldest entry; contiguous from lane 0
- deq_data  out  DEQ_W*UOP_W  head entries; lane 0 is the oldest
- deq_pop  in  $clog2(DEQ_W+1)  number of head entries consumed this cycle
- count  out  $clog2(DEPTH+1)  current occupancy
- err  out  1  sticky protocol-error flag

## Operation
- State:
  - entry array mem[DEPTH]
  - head and tail pointers, $clog2(DEPTH) bits each; wrap modulo DEPTH
  - count register
  - err register
- enq_n = popcount(enq_valid). Lane i is written to mem[(tail+i) mod DEPTH].
- Write legality:
  - A write is legal only when enq_ready=1 and enq_valid is contiguous (of the form 0..01..1).
  - Otherwise nothing is written, tail is unchanged and err is set.
- Pop legality:
  - deq_pop <= popcount(deq_valid) is legal. head advances by deq_pop modulo DEPTH.
  - deq_pop greater than the number of valid lanes is an underflow: nothing is popped and err is set.
- Occupancy update: count_next = count + enq_n(legal) - deq_pop(legal).
  - Enqueue and dequeue in the same cycle are both applied.
  - Wrap-around of either pointer past DEPTH-1 is transparent to the outputs.
- enq_ready = (count <= DEPTH-ENQ_W).
  - Conservative: computed from the registered count and ignores same-cycle pops.
  - A queue with DEPTH-ENQ_W+1 entries therefore refuses a write even if the backend pops that cycle.
- Head outputs:
  - deq_valid[i] = (count > i).
  - deq_data lane i = mem[(head+i) mod DEPTH].
  - Lanes with deq_valid[i]=0 carry don't-care data.
- flush:
  - Next state is head=tail=0 and count=0.
  - flush has priority over enq and pop in the same cycle; both are ignored and their errors are not flagged.
  - err is not cleared by flush.
- err is cleared only by reset. Error cycles never corrupt pointers or count.
- No bypass: an entry written in cycle N is first visible on deq_* in cycle N+1.

## Timing
- Reset (reset_n=0, asynchronous): head=0, tail=0, count=0, err=0.
  - Outputs during reset: enq_ready=1, deq_valid all 0, deq_data don't-care.
- Reset release:
  - reset_n rising mid-cycle takes effect with no glitch on the outputs.
  - The first enqueue can be accepted at the first clk edge after release.
- Write-to-read latency is 1 cycle. deq_pop takes effect at the same edge as the write.
- enq_ready, deq_valid and count are functions of registered state only; no combinational path from enq_* or deq_pop.
- deq_data depends combinationally only on head and mem.
- Asserting reset mid-operation discards all entries immediately; there is no drain.

## Test plan
- Fill/drain, with DEPTH=16, ENQ_W=2, DEQ_W=2:
  - Stimulus: 8 cycles of enq_valid=2'b11 with data 0..15, no pops.
  - Response: count=16 and enq_ready=0 once count exceeds 14.
  - Then 8 cycles of deq_pop=2 return 0..15 in order, ending at count=0 with deq_valid=0.
- Wrap-around:
  - Stimulus: 40 cycles of enq 2 / pop 2 in steady state, starting with 4 entries preloaded.
  - Response: count stays at 4, data order is preserved across the pointer wrap, err=0.
- Boundary ready:
  - At count=14, enq_ready=1 and an enq of 2 is accepted.
  - At count=15 with deq_pop=2, enq_ready=0 and an enq attempt sets err with count_next=13.
- Protocol errors:
  - Stimulus: enq_valid=2'b10 is driven; separately, deq_pop=2 is driven at count=1.
  - Response: err=1 each time, count and data are unchanged, and err stays set until reset.
- Flush priority:
  - Stimulus: at count=9, drive flush=1 together with enq_valid=2'b11 and deq_pop=1.
  - Response: next cycle count=0, deq_valid=0, err unchanged.
  - A subsequent enq of value 0xA5 appears on lane 0 one cycle later.
- Async reset mid-stream:
  - Stimulus: reset_n is dropped between clock edges at count=7.
  - Response: count=0, deq_valid=0, enq_ready=1 and err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uop_queue.sv
// Multi-lane circular micro-op queue: decoder enqueues up to ENQ_W, backend pops up to DEQ_W oldest.
// Latency: an entry written at edge N is visible on deq_* after that edge (no bypass).
// Backpressure: enq_ready from registered count only; illegal enq/pop is dropped and sets sticky err.
//
// Ports:
//   clk, reset_n         clock and async active-low reset
//   flush                discard all entries; overrides enq and pop in the same cycle
//   enq_valid/enq_data   per-lane write request (contiguous from lane 0) and lane payloads
//   enq_ready            a full ENQ_W-lane write fits this cycle
//   deq_valid/deq_data   oldest entries, lane 0 oldest
//   deq_pop              number of head entries consumed this cycle
//   count, err           occupancy and sticky protocol-error flag
module uop_queue #(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2,
  parameter int UOP_W = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [ENQ_W-1:0]             enq_valid,
  input  logic [ENQ_W*UOP_W-1:0]       enq_data,
  output logic                         enq_ready,
  output logic [DEQ_W-1:0]             deq_valid,
  output logic [DEQ_W*UOP_W-1:0]       deq_data,
  input  logic [$clog2(DEQ_W+1)-1:0]   deq_pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int ENQ_CW = $clog2(ENQ_W+1);

  logic [UOP_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic [ENQ_CW-1:0] enq_n;
  logic              enq_req;
  logic              enq_contig;
  logic              enq_fire;
  logic              enq_bad;
  logic              pop_ok;
  logic              pop_fire;
  logic              pop_bad;

  // Number of requested lanes.
  always_comb begin
    enq_n = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      enq_n = enq_n + ENQ_CW'(enq_valid[i]);
    end
  end

  // A mask of the form 0..01..1 has no bit in common with itself plus one.
  assign enq_contig = ((enq_valid & (enq_valid + ENQ_W'(1))) == '0);
  assign enq_req    = |enq_valid;
  assign enq_ready  = (count_q <= CNT_W'(DEPTH - ENQ_W));

  // Pop may not exceed the number of valid head lanes, i.e. min(count, DEQ_W).
  assign pop_ok   = (CNT_W'(deq_pop) <= count_q) && (int'(deq_pop) <= DEQ_W);

  // Flush masks both operations and their error reporting.
  assign enq_fire = !flush && enq_req && enq_ready && enq_contig;
  assign enq_bad  = !flush && enq_req && !(enq_ready && enq_contig);
  assign pop_fire = !flush && pop_ok;
  assign pop_bad  = !flush && !pop_ok;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | enq_bad | pop_bad;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_fire) begin
        head_d = head_q + PTR_W'(deq_pop);
      end
      if (enq_fire) begin
        tail_d = tail_q + PTR_W'(enq_n);
      end
      count_d = count_q
              + (enq_fire ? CNT_W'(enq_n)   : CNT_W'(0))
              - (pop_fire ? CNT_W'(deq_pop) : CNT_W'(0));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage carries no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (enq_valid[i]) begin
          mem_q[tail_q + PTR_W'(i)] <= enq_data[i*UOP_W +: UOP_W];
        end
      end
    end
  end

  always_comb begin
    logic [PTR_W-1:0] rd_idx;
    rd_idx    = '0;
    deq_valid = '0;
    deq_data  = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      rd_idx                     = head_q + PTR_W'(i);
      deq_valid[i]               = (count_q > CNT_W'(i));
      deq_data[i*UOP_W +: UOP_W] = mem_q[rd_idx];
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_uop_queue.sv
module tb_uop_queue;
  localparam int DEPTH = 16;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int UOP_W = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  enq_valid = '0;
  logic [31:0] enq_data = '0;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [31:0] deq_data;
  logic [1:0]  deq_pop = '0;
  logic [4:0]  count;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model: the queue contents in program order plus the sticky error bit.
  logic [15:0] mq[$];
  logic        merr = 1'b0;

  uop_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .UOP_W(UOP_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_pop(deq_pop),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    cmp({tag, ".count"}, 32'(count), mq.size());
    cmp({tag, ".ready"}, 32'(enq_ready), 32'(mq.size() <= DEPTH - ENQ_W));
    for (int i = 0; i < DEQ_W; i++) begin
      cmp($sformatf("%s.valid%0d", tag, i), 32'(deq_valid[i]), 32'(mq.size() > i));
      if (mq.size() > i)
        cmp($sformatf("%s.data%0d", tag, i), 32'(deq_data[i*UOP_W +: UOP_W]), 32'(mq[i]));
    end
    cmp({tag, ".err"}, 32'(err), 32'(merr));
  endtask

  task automatic model_apply(input logic fl, input logic [1:0] ev, input logic [15:0] d0,
                             input logic [15:0] d1, input logic [1:0] pop);
    int n, sz, avail;
    bit contig, enq_ok;
    if (fl) begin
      mq.delete();
      return;
    end
    n      = $countones(ev);
    contig = (int'(ev) == (1 << n) - 1);
    sz     = mq.size();
    avail  = (sz < DEQ_W) ? sz : DEQ_W;
    enq_ok = (n > 0) && (sz <= DEPTH - ENQ_W) && contig;
    if (n > 0 && !enq_ok) merr = 1'b1;
    if (int'(pop) <= avail) begin
      repeat (int'(pop)) void'(mq.pop_front());
    end else begin
      merr = 1'b1;
    end
    if (enq_ok) begin
      mq.push_back(d0);
      if (n == 2) mq.push_back(d1);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model; returns at edge+1.
  task automatic step(input logic fl, input logic [1:0] ev, input logic [15:0] d0,
                      input logic [15:0] d1, input logic [1:0] pop);
    flush     = fl;
    enq_valid = ev;
    enq_data  = {d1, d0};
    deq_pop   = pop;
    @(posedge clk);
    #1;
    model_apply(fl, ev, d0, d1, pop);
    flush     = 1'b0;
    enq_valid = '0;
    deq_pop   = '0;
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    mq.delete();
    merr = 1'b0;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fl;
    logic [1:0]  ev;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  pop;
    int          exp_cnt;
    logic        exp_err;
    logic [15:0] exp_l0;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int v, rd;
    tbl[0] = '{1'b0, 2'b11, 16'h10, 16'h11, 2'd0, 2, 1'b0, 16'h10};
    tbl[1] = '{1'b0, 2'b01, 16'h12, 16'h00, 2'd1, 2, 1'b0, 16'h11};
    tbl[2] = '{1'b0, 2'b10, 16'h33, 16'h34, 2'd0, 2, 1'b1, 16'h11};
    tbl[3] = '{1'b0, 2'b00, 16'h00, 16'h00, 2'd2, 0, 1'b1, 16'h00};
    tbl[4] = '{1'b0, 2'b11, 16'h20, 16'h21, 2'd1, 2, 1'b1, 16'h20};
    tbl[5] = '{1'b0, 2'b00, 16'h00, 16'h00, 2'd3, 2, 1'b1, 16'h20};
    tbl[6] = '{1'b1, 2'b11, 16'h44, 16'h45, 2'd1, 0, 1'b1, 16'h00};
    tbl[7] = '{1'b0, 2'b01, 16'hA5, 16'h00, 2'd0, 1, 1'b1, 16'hA5};

    // Reset state while reset is held.
    #2;
    cmp("rst.count", 32'(count), 0);
    cmp("rst.ready", 32'(enq_ready), 1);
    cmp("rst.valid", 32'(deq_valid), 0);
    cmp("rst.err", 32'(err), 0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven directed vectors.
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].fl, tbl[k].ev, tbl[k].d0, tbl[k].d1, tbl[k].pop);
      cmp($sformatf("tbl%0d.count", k), 32'(count), 32'(tbl[k].exp_cnt));
      cmp($sformatf("tbl%0d.err", k), 32'(err), 32'(tbl[k].exp_err));
      if (tbl[k].exp_cnt > 0)
        cmp($sformatf("tbl%0d.lane0", k), 32'(deq_data[15:0]), 32'(tbl[k].exp_l0));
      check_state($sformatf("tbl%0d", k));
    end

    // Fill then drain.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b11, 16'(2*i), 16'(2*i+1), 2'd0);
      check_state("fill");
    end
    cmp("fill.count16", 32'(count), 16);
    cmp("fill.ready0", 32'(enq_ready), 0);
    for (int i = 0; i < 8; i++) begin
      cmp("drain.lane0", 32'(deq_data[15:0]), 32'(2*i));
      cmp("drain.lane1", 32'(deq_data[31:16]), 32'(2*i+1));
      step(1'b0, 2'b00, 16'h0, 16'h0, 2'd2);
      check_state("drain");
    end
    cmp("drain.count0", 32'(count), 0);
    cmp("drain.valid0", 32'(deq_valid), 0);

    // Steady-state enq 2 / pop 2 across pointer wrap.
    do_reset();
    v = 0; rd = 0;
    repeat (2) begin step(1'b0, 2'b11, 16'(v), 16'(v+1), 2'd0); v += 2; end
    for (int i = 0; i < 40; i++) begin
      cmp("wrap.lane0", 32'(deq_data[15:0]), 32'(rd));
      step(1'b0, 2'b11, 16'(v), 16'(v+1), 2'd2);
      v += 2; rd += 2;
      cmp("wrap.count4", 32'(count), 4);
      check_state("wrap");
    end
    cmp("wrap.err0", 32'(err), 0);

    // Ready boundary at 14 and 15.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 2'b11, 16'(i), 16'(i), 2'd0);
    cmp("bnd14.ready", 32'(enq_ready), 1);
    step(1'b0, 2'b11, 16'h77, 16'h78, 2'd0);
    cmp("bnd14.count", 32'(count), 16);
    step(1'b0, 2'b00, 16'h0, 16'h0, 2'd1);
    cmp("bnd15.ready", 32'(enq_ready), 0);
    step(1'b0, 2'b11, 16'h99, 16'h9A, 2'd2);
    cmp("bnd15.count", 32'(count), 13);
    cmp("bnd15.err", 32'(err), 1);
    check_state("bnd15");

    // Protocol errors: non-contiguous enq, then underflow pop.
    do_reset();
    step(1'b0, 2'b11, 16'h1, 16'h2, 2'd0);
    step(1'b0, 2'b10, 16'h3, 16'h4, 2'd0);
    cmp("nc.err", 32'(err), 1);
    cmp("nc.count", 32'(count), 2);
    cmp("nc.lane1", 32'(deq_data[31:16]), 32'h2);
    do_reset();
    step(1'b0, 2'b01, 16'h5, 16'h0, 2'd0);
    step(1'b0, 2'b00, 16'h0, 16'h0, 2'd2);
    cmp("uf.err", 32'(err), 1);
    cmp("uf.count", 32'(count), 1);
    cmp("uf.lane0", 32'(deq_data[15:0]), 32'h5);
    repeat (3) step(1'b0, 2'b00, 16'h0, 16'h0, 2'd0);
    cmp("uf.sticky", 32'(err), 1);

    // Flush priority at count 9.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 2'b11, 16'(i), 16'(i), 2'd0);
    step(1'b0, 2'b01, 16'h8, 16'h0, 2'd0);
    cmp("fl.pre", 32'(count), 9);
    step(1'b1, 2'b11, 16'h1, 16'h2, 2'd1);
    cmp("fl.count", 32'(count), 0);
    cmp("fl.valid", 32'(deq_valid), 0);
    cmp("fl.err", 32'(err), 0);
    step(1'b0, 2'b01, 16'hA5, 16'h0, 2'd0);
    cmp("fl.a5", 32'(deq_data[15:0]), 32'hA5);
    cmp("fl.v1", 32'(deq_valid), 1);

    // Async reset between edges at count 7, with err set beforehand.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 16'(i), 16'(i), 2'd0);
    step(1'b0, 2'b01, 16'h7, 16'h0, 2'd0);
    step(1'b0, 2'b10, 16'h0, 16'h0, 2'd0);
    cmp("ar.pre", 32'(count), 7);
    cmp("ar.preerr", 32'(err), 1);
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    merr = 1'b0;
    cmp("ar.count", 32'(count), 0);
    cmp("ar.valid", 32'(deq_valid), 0);
    cmp("ar.ready", 32'(enq_ready), 1);
    cmp("ar.err", 32'(err), 0);
    #2;
    reset_n = 1'b1;
    step(1'b0, 2'b01, 16'h3C, 16'h0, 2'd0);
    cmp("ar.first", 32'(count), 1);
    check_state("ar");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        fl;
      logic [1:0]  ev, pop;
      fl  = ($urandom_range(0, 49) == 0);
      ev  = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 3) == 0 ? 0 :
            ($urandom_range(0, 1) == 0 ? 1 : 3));
      pop = 2'($urandom_range(0, 3) == 3 ? $urandom_range(0, 3) : $urandom_range(0, 2));
      step(fl, ev, 16'($urandom), 16'($urandom), pop);
      check_state("rnd");
      if (($urandom_range(0, 299) == 0)) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
